clint_ctrl: RTL and testbench
=============================

# clint_ctrl

Core-local interrupt and exception controller. It is the machine-mode trap sequencer that drives the CLINT-side write/read port of the CSR register file. It detects ECALL, EBREAK and MRET in the decode stage and asynchronous timer/external interrupts. For each event it holds the pipeline, sequences the required mepc/mstatus/mcause CSR writes, and then redirects fetch to mtvec or to mepc.

## Interface
Parameters:
- INT_W, 8, width of the interrupt request vector.
- ASYNC_CAUSE, 64'h8000_0000_0000_0007, mcause value written for an asynchronous interrupt (machine timer).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- int_flag_i  in  INT_W  level interrupt requests; any nonzero bit is a request.
- inst_i  in  32  instruction currently in decode.
- inst_addr_i  in  64  PC of inst_i.
- jump_flag_i  in  1  execute stage is redirecting this cycle.
- jump_addr_i  in  64  redirect target from execute.
- hold_flag_i  in  1  pipeline is held by another unit (e.g. divider busy).
- csr_mtvec_i  in  64  current mtvec.
- csr_mepc_i  in  64  current mepc.
- csr_mstatus_i  in  64  current mstatus.
- global_int_en_i  in  1  mstatus.MIE.
- we_o  out  1  CSR write enable (CLINT port).
- waddr_o  out  64  CSR write address; only bits [11:0] are meaningful.
- raddr_o  out  64  CSR read address; tied to 0 (reserved).
- data_o  out  64  CSR write data.
- hold_flag_o  out  1  stall request to the pipeline controller.
- int_assert_o  out  1  one-cycle fetch redirect strobe.
- int_addr_o  out  64  redirect target, valid while int_assert_o is high.

## Operation
Event detection is combinational and is evaluated only while the CSR sequencer is in S_IDLE. Priority is:
- **SYNC:** inst_i == 32'h0000_0073 (ECALL, cause 11) or inst_i == 32'h0010_0073 (EBREAK, cause 3).
- **ASYNC:** int_flag_i != 0, global_int_en_i == 1 and hold_flag_i == 0.
- **MRET:** inst_i == 32'h3020_0073.

The sequencer is a 5-state FSM: S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET.

- **S_IDLE, SYNC or ASYNC detected:**
  - Capture the cause into a 64-bit register: SYNC uses 11 or 3; ASYNC uses ASYNC_CAUSE.
  - Capture epc: SYNC uses inst_addr_i. ASYNC uses jump_addr_i if jump_flag_i is high, otherwise inst_addr_i.
  - Go to S_MEPC.
- **S_IDLE, MRET detected:** go to S_MRET.
- **S_MEPC:** we_o=1, waddr_o=12'h341, data_o=epc. Go to S_MSTATUS.
- **S_MSTATUS:** we_o=1, waddr_o=12'h300, data_o = mstatus with bit7 (MPIE) set to the old bit3 and bit3 (MIE) cleared. All other bits are unchanged. Go to S_MCAUSE.
- **S_MCAUSE:** we_o=1, waddr_o=12'h342, data_o=cause. Go to S_IDLE and pulse int_assert_o with int_addr_o=csr_mtvec_i.
- **S_MRET:** we_o=1, waddr_o=12'h300, data_o = mstatus with bit3 set to old bit7 and bit7 set to 1. Go to S_IDLE and pulse int_assert_o with int_addr_o=csr_mepc_i.

Other rules:
- hold_flag_o = (state != S_IDLE) | event detected this cycle.
- In S_IDLE we_o=0, waddr_o=0 and data_o=0.
- Level interrupts that stay asserted re-trigger only after software re-enables MIE.

## Timing
Reset values: every output is 0, state is S_IDLE, and the cause and epc registers are 0.

Trap (SYNC or ASYNC) detected in cycle N:
- hold_flag_o is high in cycles N..N+3.
- CSR writes take effect at the edges ending cycles N+1, N+2 and N+3.
- int_assert_o is registered and high for cycle N+4 only, with int_addr_o equal to the mtvec sampled in N+3.
- hold_flag_o is low in N+4 unless a new event is detected.

MRET detected in cycle N:
- hold_flag_o is high in N..N+1.
- The mstatus write lands at the end of N+1.
- int_assert_o is high in N+2 with int_addr_o equal to the mepc sampled in N+1.

Boundary conditions:
- SYNC and ASYNC in the same cycle: SYNC wins. ASYNC is re-evaluated after return to S_IDLE.
- Events arriving while the FSM is busy are ignored.
- ASYNC while hold_flag_i=1 is deferred.
- rst low in any state: next edge forces S_IDLE, clears all outputs, and abandons partial CSR sequences.

## Structure
- Shared package/defines: CSR addresses (MTVEC 0x305, MCAUSE 0x342, MEPC 0x341, MIE 0x304, MSTATUS 0x300, MSCRATCH 0x340), ECALL/EBREAK/MRET encodings, cause codes and FSM state encodings.
- Single module, no sub-modules.

## Test plan
- **ECALL at PC 0x8000_0010, mstatus=0x8, mtvec=0x8000_0100:** writes in order are mepc=0x8000_0010, mstatus=0x80, mcause=11. int_assert_o is high one cycle with int_addr_o=0x8000_0100. hold_flag_o is high for 4 cycles.
- **int_flag_i=1, MIE=1, jump_flag_i=1 with jump_addr_i=0x200:** mepc=0x200 and mcause=0x8000_0000_0000_0007.
- **int_flag_i=1 with MIE=0, or with hold_flag_i=1:** no write and no hold. Dropping hold_flag_i triggers the trap the next cycle.
- **MRET with mstatus=0x80, mepc=0x8000_0014:** mstatus write is 0x88. int_assert_o is high with int_addr_o=0x8000_0014 two cycles after detection.
- **EBREAK and int_flag_i asserted together:** mcause=3 first, then the async trap after MIE is restored.
- **rst=0 asserted in S_MSTATUS:** next cycle all outputs are 0, no mcause write occurs and int_assert_o never pulses.

Source files
------------

// File: rtl/clint_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// SYSTEM instruction encodings, trap cause codes and sequencer states.
package clint_ctrl_pkg;

  // CSR addresses touched (or referenced) by the trap sequencer
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  // SYSTEM opcode encodings recognised in decode
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // Synchronous exception cause codes
  localparam logic [63:0] CAUSE_ECALL_M   = 64'd11;
  localparam logic [63:0] CAUSE_BREAKPNT  = 64'd3;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MSTATUS,
    S_MCAUSE,
    S_MRET
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_SYNC,
    EV_ASYNC,
    EV_MRET
  } event_t;

  // Trap entry: stash MIE into MPIE and disable interrupts.
  function automatic logic [63:0] trap_mstatus(input logic [63:0] m);
    logic [63:0] r;
    r               = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and leave MPIE set.
  function automatic logic [63:0] mret_mstatus(input logic [63:0] m);
    logic [63:0] r;
    r               = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_ctrl.sv
// Core-local trap sequencer: detects ECALL/EBREAK/MRET and level interrupts,
// stalls the pipeline, writes mepc/mstatus/mcause, then redirects fetch.
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter int          INT_W       = 8,
  parameter logic [63:0] ASYNC_CAUSE = 64'h8000_0000_0000_0007
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      inst_i,
  input  logic [63:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [63:0]      jump_addr_i,
  input  logic             hold_flag_i,
  input  logic [63:0]      csr_mtvec_i,
  input  logic [63:0]      csr_mepc_i,
  input  logic [63:0]      csr_mstatus_i,
  input  logic             global_int_en_i,
  output logic             we_o,
  output logic [63:0]      waddr_o,
  output logic [63:0]      raddr_o,
  output logic [63:0]      data_o,
  output logic             hold_flag_o,
  output logic             int_assert_o,
  output logic [63:0]      int_addr_o
);

  state_t      state;
  event_t      ev;
  logic [63:0] cause;
  logic [63:0] epc;
  logic [11:0] csr_addr;

  // Event detection only matters in S_IDLE; anything arriving while the
  // sequencer is busy is dropped rather than queued.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    ev = EV_NONE;
    if (state == S_IDLE) begin
      if (inst_i == INST_ECALL || inst_i == INST_EBREAK) begin
        ev = EV_SYNC;
      end else if ((|int_flag_i) && global_int_en_i && !hold_flag_i) begin
        ev = EV_ASYNC;
      end else if (inst_i == INST_MRET) begin
        ev = EV_MRET;
      end
    end
  end

  assign hold_flag_o = (state != S_IDLE) || (ev != EV_NONE);

  // CSR write port is a pure decode of the current state.
  always_comb begin
    we_o     = 1'b0;
    csr_addr = '0;
    data_o   = '0;
    unique case (state)
      S_MEPC: begin
        we_o     = 1'b1;
        csr_addr = CSR_MEPC;
        data_o   = epc;
      end
      S_MSTATUS: begin
        we_o     = 1'b1;
        csr_addr = CSR_MSTATUS;
        data_o   = trap_mstatus(csr_mstatus_i);
      end
      S_MCAUSE: begin
        we_o     = 1'b1;
        csr_addr = CSR_MCAUSE;
        data_o   = cause;
      end
      S_MRET: begin
        we_o     = 1'b1;
        csr_addr = CSR_MSTATUS;
        data_o   = mret_mstatus(csr_mstatus_i);
      end
      default: ;
    endcase
  end

  assign waddr_o = {52'd0, csr_addr};
  assign raddr_o = '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      cause        <= '0;
      epc          <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      unique case (state)
        S_IDLE: begin
          unique case (ev)
            EV_SYNC: begin
              cause <= (inst_i == INST_ECALL) ? CAUSE_ECALL_M : CAUSE_BREAKPNT;
              epc   <= inst_addr_i;
              state <= S_MEPC;
            end
            EV_ASYNC: begin
              // An interrupt taken under a redirect must resume at the target.
              cause <= ASYNC_CAUSE;
              epc   <= jump_flag_i ? jump_addr_i : inst_addr_i;
              state <= S_MEPC;
            end
            EV_MRET: state <= S_MRET;
            default: ;
          endcase
        end
        S_MEPC:    state <= S_MSTATUS;
        S_MSTATUS: state <= S_MCAUSE;
        S_MCAUSE: begin
          state        <= S_IDLE;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mtvec_i;
        end
        S_MRET: begin
          state        <= S_IDLE;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mepc_i;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed bench for clint_ctrl: inputs change just after each falling edge,
// outputs are checked 1ns later, well clear of the rising edge.
module tb_clint_ctrl;

  localparam logic [63:0] MTVEC   = 64'h8000_0100;
  localparam logic [63:0] A_CAUSE = 64'h8000_0000_0000_0007;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ECALL   = 32'h0000_0073;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [31:0] MRET    = 32'h3020_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i;
  logic [63:0] inst_addr_i;
  logic        jump_flag_i;
  logic [63:0] jump_addr_i;
  logic        hold_flag_i;
  logic [63:0] csr_mtvec_i;
  logic [63:0] csr_mepc_i;
  logic [63:0] csr_mstatus_i;
  logic        global_int_en_i;
  logic        we_o;
  logic [63:0] waddr_o;
  logic [63:0] raddr_o;
  logic [63:0] data_o;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [63:0] int_addr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clint_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .int_flag_i     (int_flag_i),
    .inst_i         (inst_i),
    .inst_addr_i    (inst_addr_i),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .hold_flag_i    (hold_flag_i),
    .csr_mtvec_i    (csr_mtvec_i),
    .csr_mepc_i     (csr_mepc_i),
    .csr_mstatus_i  (csr_mstatus_i),
    .global_int_en_i(global_int_en_i),
    .we_o           (we_o),
    .waddr_o        (waddr_o),
    .raddr_o        (raddr_o),
    .data_o         (data_o),
    .hold_flag_o    (hold_flag_o),
    .int_assert_o   (int_assert_o),
    .int_addr_o     (int_addr_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // CSR write port expectation for the current cycle.
  task automatic exp_csr(input string tag, input logic we, input logic [63:0] addr,
                         input logic [63:0] data);
    check({tag, ".we"}, {63'd0, we_o}, {63'd0, we});
    check({tag, ".waddr"}, waddr_o, addr);
    check({tag, ".data"}, data_o, data);
  endtask

  // Pipeline-control expectation; the redirect target only matters with the strobe.
  task automatic exp_ctl(input string tag, input logic hold, input logic ia,
                         input logic [63:0] iaddr);
    check({tag, ".hold"}, {63'd0, hold_flag_o}, {63'd0, hold});
    check({tag, ".int_assert"}, {63'd0, int_assert_o}, {63'd0, ia});
    if (ia) check({tag, ".int_addr"}, int_addr_o, iaddr);
  endtask

  // Advance to the middle of the next cycle.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst             = 1'b0;
    int_flag_i      = '0;
    inst_i          = NOP;
    inst_addr_i     = '0;
    jump_flag_i     = 1'b0;
    jump_addr_i     = '0;
    hold_flag_i     = 1'b0;
    csr_mtvec_i     = MTVEC;
    csr_mepc_i      = '0;
    csr_mstatus_i   = '0;
    global_int_en_i = 1'b0;

    // Reset state
    step(); step(); settle();
    exp_csr("reset", 1'b0, 64'h0, 64'h0);
    exp_ctl("reset", 1'b0, 1'b0, 64'h0);
    check("reset.int_addr", int_addr_o, 64'h0);
    check("reset.raddr", raddr_o, 64'h0);
    rst = 1'b1;

    // ECALL at 0x8000_0010 with MIE set
    step();
    inst_i = ECALL; inst_addr_i = 64'h8000_0010;
    csr_mstatus_i = 64'h8; global_int_en_i = 1'b1;
    settle();
    exp_ctl("ecall.n0", 1'b1, 1'b0, 0);
    exp_csr("ecall.n0", 1'b0, 64'h0, 64'h0);
    step(); inst_i = NOP; settle();
    exp_ctl("ecall.n1", 1'b1, 1'b0, 0);
    exp_csr("ecall.mepc", 1'b1, 64'h341, 64'h8000_0010);
    step(); settle();
    exp_ctl("ecall.n2", 1'b1, 1'b0, 0);
    exp_csr("ecall.mstatus", 1'b1, 64'h300, 64'h80);
    step(); csr_mstatus_i = 64'h80; global_int_en_i = 1'b0; settle();
    exp_ctl("ecall.n3", 1'b1, 1'b0, 0);
    exp_csr("ecall.mcause", 1'b1, 64'h342, 64'd11);
    step(); settle();
    exp_ctl("ecall.n4", 1'b0, 1'b1, MTVEC);
    exp_csr("ecall.n4", 1'b0, 64'h0, 64'h0);
    step(); settle();
    exp_ctl("ecall.n5", 1'b0, 1'b0, 0);

    // Interrupt under an execute-stage redirect; an ECALL while busy is ignored
    step();
    csr_mstatus_i = 64'h8; global_int_en_i = 1'b1; int_flag_i = 8'h01;
    jump_flag_i = 1'b1; jump_addr_i = 64'h200; inst_addr_i = 64'h1000;
    settle();
    exp_ctl("irq.n0", 1'b1, 1'b0, 0);
    step(); jump_flag_i = 1'b0; inst_i = ECALL; settle();
    exp_csr("irq.mepc", 1'b1, 64'h341, 64'h200);
    step(); inst_i = NOP; settle();
    exp_csr("irq.mstatus", 1'b1, 64'h300, 64'h80);
    step(); csr_mstatus_i = 64'h80; global_int_en_i = 1'b0; settle();
    exp_csr("irq.mcause", 1'b1, 64'h342, A_CAUSE);
    step(); settle();
    // Request still high but MIE now clear: no re-trigger
    exp_ctl("irq.n4", 1'b0, 1'b1, MTVEC);
    exp_csr("irq.n4", 1'b0, 64'h0, 64'h0);

    // MIE=0 keeps the level request pending
    step(); settle();
    exp_ctl("mie0", 1'b0, 1'b0, 0);
    exp_csr("mie0", 1'b0, 64'h0, 64'h0);
    // MIE=1 but pipeline held: deferred
    step(); csr_mstatus_i = 64'h8; global_int_en_i = 1'b1; hold_flag_i = 1'b1; settle();
    exp_ctl("held.a", 1'b0, 1'b0, 0);
    step(); settle();
    exp_ctl("held.b", 1'b0, 1'b0, 0);
    exp_csr("held.b", 1'b0, 64'h0, 64'h0);
    // Dropping the hold takes the trap in that cycle
    step(); hold_flag_i = 1'b0; settle();
    exp_ctl("unheld.n0", 1'b1, 1'b0, 0);
    step(); settle();
    exp_csr("unheld.mepc", 1'b1, 64'h341, 64'h1000);
    step(); settle();
    exp_csr("unheld.mstatus", 1'b1, 64'h300, 64'h80);

    // Reset in S_MSTATUS abandons the sequence
    rst = 1'b0; int_flag_i = '0; global_int_en_i = 1'b0;
    step(); settle();
    exp_csr("rst_mid", 1'b0, 64'h0, 64'h0);
    exp_ctl("rst_mid", 1'b0, 1'b0, 0);
    check("rst_mid.int_addr", int_addr_o, 64'h0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      check($sformatf("post_rst%0d.we", i), {63'd0, we_o}, 64'd0);
      check($sformatf("post_rst%0d.int_assert", i), {63'd0, int_assert_o}, 64'd0);
    end

    // MRET with MPIE set
    step();
    csr_mstatus_i = 64'h80; csr_mepc_i = 64'h8000_0014; inst_i = MRET;
    settle();
    exp_ctl("mret.n0", 1'b1, 1'b0, 0);
    exp_csr("mret.n0", 1'b0, 64'h0, 64'h0);
    step(); inst_i = NOP; settle();
    exp_ctl("mret.n1", 1'b1, 1'b0, 0);
    exp_csr("mret.mstatus", 1'b1, 64'h300, 64'h88);
    step(); csr_mstatus_i = 64'h88; settle();
    exp_ctl("mret.n2", 1'b0, 1'b1, 64'h8000_0014);
    exp_csr("mret.n2", 1'b0, 64'h0, 64'h0);
    step(); settle();
    exp_ctl("mret.n3", 1'b0, 1'b0, 0);

    // EBREAK and interrupt together: EBREAK first
    step();
    csr_mstatus_i = 64'h8; global_int_en_i = 1'b1; int_flag_i = 8'h40;
    inst_i = EBREAK; inst_addr_i = 64'h8000_0020;
    settle();
    exp_ctl("ebrk.n0", 1'b1, 1'b0, 0);
    step(); inst_i = NOP; inst_addr_i = 64'h8000_0024; settle();
    exp_csr("ebrk.mepc", 1'b1, 64'h341, 64'h8000_0020);
    step(); settle();
    exp_csr("ebrk.mstatus", 1'b1, 64'h300, 64'h80);
    step(); csr_mstatus_i = 64'h80; global_int_en_i = 1'b0; settle();
    exp_csr("ebrk.mcause", 1'b1, 64'h342, 64'd3);
    step(); settle();
    exp_ctl("ebrk.n4", 1'b0, 1'b1, MTVEC);
    // Software restores MIE: pending interrupt is now taken
    step(); csr_mstatus_i = 64'h88; global_int_en_i = 1'b1; settle();
    exp_ctl("late_irq.n0", 1'b1, 1'b0, 0);
    step(); settle();
    exp_csr("late_irq.mepc", 1'b1, 64'h341, 64'h8000_0024);
    step(); settle();
    exp_csr("late_irq.mstatus", 1'b1, 64'h300, 64'h80);
    step(); csr_mstatus_i = 64'h80; global_int_en_i = 1'b0; int_flag_i = '0; settle();
    exp_csr("late_irq.mcause", 1'b1, 64'h342, A_CAUSE);
    step(); settle();
    exp_ctl("late_irq.n4", 1'b0, 1'b1, MTVEC);
    step(); settle();
    exp_ctl("late_irq.n5", 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
